// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and counter widths for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RES  = 8'hAB;

    localparam int CNT_W     = 5;
    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_t;

    // Byte idx of a 3-byte JEDEC ID, MSB first; past the end reads as zero.
    function automatic logic [7:0] id_byte(input logic [23:0] jedec, input logic [1:0] idx);
        case (idx)
            2'd0:    return jedec[23:16];
            2'd1:    return jedec[15:8];
            2'd2:    return jedec[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// Byte RAM: host write port plus a registered read port for the SPI fetch path.
module spi_flash_mem #(
    parameter int MEM_BYTES = 4096
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_BYTES)-1:0] waddr,
    input  logic [7:0]                   wdata,
    input  logic [$clog2(MEM_BYTES)-1:0] raddr,
    output logic [7:0]                   rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave model of a serial NOR flash (READ / RDID / RES), oversampled on clk.
//   state  | meaning
//   IDLE   | CS_N high, waiting for a frame
//   CMD    | shifting in the 8-bit opcode
//   ADDR   | shifting in the 24-bit read address
//   DATA   | streaming memory bytes from addr_reg
//   ID     | streaming the JEDEC ID, then zeros
//   IGNORE | unsupported opcode or frame joined mid-way; silent until CS_N rises
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          MEM_BYTES = 4096,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CLK,
    input  logic        CS_N,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        active
);

    localparam int AW = $clog2(MEM_BYTES);

    state_t     state;
    logic       cs_s1, cs_s2;
    logic       sck_s1, sck_s2, sck_d;
    logic       mosi_s1, mosi_s2;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0] cmd_reg;
    logic [23:0] addr_reg;
    logic [7:0] shift_out;
    logic [1:0] id_idx;
    logic       armed;
    logic [1:0] settle;
    logic [7:0] mem_rdata;

    logic       sck_rise, sck_fall;
    logic [7:0] cmd_next;
    logic [7:0] id_cur;
    logic       unused_addr_bits;

    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign cmd_next = {cmd_reg[6:0], mosi_s2};
    assign id_cur   = id_byte(JEDEC_ID, id_idx);
    assign unused_addr_bits = ^{load_addr[31:AW], addr_reg[23:AW]};

    spi_flash_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
        .clk   (clk),
        .we    (load_we),
        .waddr (load_addr[AW-1:0]),
        .wdata (load_data),
        .raddr (addr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            MISO      <= 1'b0;
            active    <= 1'b0;
            bit_cnt   <= '0;
            addr_reg  <= '0;
            cmd_reg   <= '0;
            shift_out <= '0;
            id_idx    <= '0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_d     <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            armed     <= 1'b0;
            settle    <= 2'd2;
        end else begin
            cs_s1   <= CS_N;
            cs_s2   <= cs_s1;
            sck_s1  <= CLK;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;

            // cs_s2 only reflects the pin once the synchroniser has refilled after reset;
            // a frame may start decoding only after CS_N has genuinely been seen high.
            if (settle != 2'd0) begin
                settle <= settle - 2'd1;
            end else if (cs_s2) begin
                armed <= 1'b1;
            end

            if (cs_s2) begin
                state   <= IDLE;
                active  <= 1'b0;
                MISO    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        MISO    <= 1'b0;
                        bit_cnt <= '0;
                        active  <= 1'b1;
                        state   <= armed ? CMD : IGNORE;
                    end
                    CMD: begin
                        MISO <= 1'b0;
                        if (sck_rise) begin
                            cmd_reg <= cmd_next;
                            if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                                bit_cnt <= '0;
                                case (cmd_next)
                                    OP_READ: state <= ADDR;
                                    OP_RDID: begin
                                        state  <= ID;
                                        id_idx <= 2'd0;
                                    end
                                    OP_RES:  state <= IGNORE;
                                    default: state <= IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ADDR: begin
                        MISO <= 1'b0;
                        if (sck_rise) begin
                            addr_reg <= {addr_reg[22:0], mosi_s2};
                            if (bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        // bit_cnt==0 marks the fetch edge: the byte is latched here, so a
                        // host write landing in the same cycle does not affect it.
                        if (sck_fall) begin
                            if (bit_cnt == '0) begin
                                MISO      <= mem_rdata[7];
                                shift_out <= {mem_rdata[6:0], 1'b0};
                            end else begin
                                MISO      <= shift_out[7];
                                shift_out <= {shift_out[6:0], 1'b0};
                            end
                            if (bit_cnt == CNT_W'(7)) begin
                                bit_cnt  <= '0;
                                addr_reg <= addr_reg + 24'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ID: begin
                        if (sck_fall) begin
                            if (bit_cnt == '0) begin
                                MISO      <= id_cur[7];
                                shift_out <= {id_cur[6:0], 1'b0};
                            end else begin
                                MISO      <= shift_out[7];
                                shift_out <= {shift_out[6:0], 1'b0};
                            end
                            if (bit_cnt == CNT_W'(7)) begin
                                bit_cnt <= '0;
                                if (id_idx != 2'd3) begin
                                    id_idx <= id_idx + 2'd1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    IGNORE: begin
                        MISO <= 1'b0;
                    end
                    default: begin
                        MISO  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboarded bench: bit-banged SPI master against the flash responder model.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        CLK;
    logic        CS_N;
    logic        MOSI;
    logic        MISO;
    logic        load_we;
    logic [31:0] load_addr;
    logic [7:0]  load_data;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    spi_flash_responder #(.MEM_BYTES(4096), .JEDEC_ID(24'hEF4016)) dut (
        .clk       (clk),
        .reset     (reset),
        .CLK       (CLK),
        .CS_N      (CS_N),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .active    (active)
    );

    task automatic half_sck();
        repeat (5) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = tx[i];
            half_sck();
            CLK = 1'b1;
            rx = {rx[30:0], MISO};
            half_sck();
            CLK = 1'b0;
        end
    endtask

    task automatic frame_start();
        CS_N = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (3) @(negedge clk);
        CS_N = 1'b1;
        MOSI = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic host_write(input logic [31:0] addr, input logic [7:0] data);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_we   = 1'b0;
    endtask

    // Opens a frame, sends op (+ address), clocks nbytes and queues what came back.
    task automatic spi_cmd(input logic [7:0] op, input bit with_addr, input logic [23:0] addr,
                           input int nbytes);
        logic [31:0] rx;
        frame_start();
        spi_bits({24'h0, op}, 8, rx);
        if (with_addr) spi_bits({8'h0, addr}, 24, rx);
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(32'h0, 8, rx);
            got_q.push_back(rx[7:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; CLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b want 0", active); end
    endtask

    task automatic test_read_basic();
        logic [7:0] e, g;
        host_write(32'h000, 8'h12);
        host_write(32'h001, 8'h34);
        host_write(32'h002, 8'h56);
        host_write(32'h003, 8'h78);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        spi_cmd(8'h03, 1'b1, 24'h000000, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL read_basic: got %02h want %02h", g, e); end
        end
        repeat (3) @(negedge clk);
        CS_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (active === 1'b0) break;
        end
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL read_basic_release: active %b want 0 within 3 clk", active); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] e, g;
        host_write(32'hFFF, 8'hAA);
        host_write(32'h000, 8'h55);
        exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
        spi_cmd(8'h03, 1'b1, 24'h000FFF, 2);
        frame_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL wrap: got %02h want %02h", g, e); end
        end
    endtask

    task automatic test_rdid();
        logic [7:0] e, g;
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
        exp_q.push_back(8'h16); exp_q.push_back(8'h00);
        spi_cmd(8'h9F, 1'b0, 24'h0, 4);
        frame_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rdid: got %02h want %02h", g, e); end
        end
    endtask

    task automatic test_invalid_opcode();
        logic [7:0] e, g;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        spi_cmd(8'h5A, 1'b0, 24'h0, 2);
        n_checks++;
        if (active !== 1'b1) begin n_fail++; $display("FAIL invalid_active: got %b want 1", active); end
        frame_end();
        exp_q.push_back(8'h34);
        spi_cmd(8'h03, 1'b1, 24'h000001, 1);
        frame_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL invalid_opcode: got %02h want %02h", g, e); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        logic [7:0]  e, g;
        frame_start();
        spi_bits(32'h03, 8, rx);
        spi_bits(32'h0, 12, rx);
        frame_end();
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL abort_active: got %b want 0", active); end
        n_checks++;
        if (MISO !== 1'b0) begin n_fail++; $display("FAIL abort_miso: got %b want 0", MISO); end
        exp_q.push_back(8'h56);
        spi_cmd(8'h03, 1'b1, 24'h000002, 1);
        frame_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL abort_next_read: got %02h want %02h", g, e); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rx;
        logic [7:0]  e, g;
        frame_start();
        spi_bits(32'h03, 8, rx);
        spi_bits(32'h0, 8, rx);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (MISO !== 1'b0) begin n_fail++; $display("FAIL midreset_miso: got %b want 0", MISO); end
            n_checks++;
            if (active !== 1'b0) begin n_fail++; $display("FAIL midreset_active: got %b want 0", active); end
        end
        @(negedge clk);
        reset = 1'b0;
        spi_bits(32'h0, 16, rx);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        spi_bits(32'h0, 8, rx);
        got_q.push_back(rx[7:0]);
        spi_bits(32'h0, 8, rx);
        got_q.push_back(rx[7:0]);
        n_checks++;
        if (active !== 1'b1) begin n_fail++; $display("FAIL midreset_ignore_active: got %b want 1", active); end
        frame_end();
        exp_q.push_back(8'h78);
        spi_cmd(8'h03, 1'b1, 24'h000003, 1);
        frame_end();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL reset_mid_frame: got %02h want %02h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_wrap();
        test_rdid();
        test_invalid_opcode();
        test_abort();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
